mips_boot_ctrl: RTL

Boot and memory-port controller for the multicycle MIPS core. It holds the core in reset and loads a program image from a byte stream into the core's 8-bit unified memory, then verifies a checksum and releases the core. While the core runs, the block passes the core's memory port straight through to memory. It sits between `mini_mips` and the memory model and owns the single memory write port.

---
 rtl/mips_boot_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mips_boot_ctrl.sv
// Boot and memory-port controller for the multicycle MIPS core.
// Holds the core in reset and streams a length-prefixed program image into
// the core's 8-bit unified memory. It then verifies a one-byte additive
// checksum and releases the core after a short delay. While the core runs,
// the core's memory port is passed straight through to memory.
module mips_boot_ctrl #(
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter int unsigned RELEASE_DLY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic       reload,
  input  logic       cpu_memwrite,
  input  logic [7:0] cpu_adr,
  input  logic [7:0] cpu_writedata,
  output logic       mem_we,
  output logic [7:0] mem_adr,
  output logic [7:0] mem_wd,
  output logic       cpu_reset,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_HOLD,
    ST_RUN,
    ST_ERR
  } state_t;

  localparam logic [3:0] DLY_INIT = 4'(RELEASE_DLY);

  state_t     state_q, state_d;
  logic [8:0] remaining_q, remaining_d;  // 9 bits: a length byte of 0 means 256
  logic [7:0] idx_q, idx_d;
  logic [7:0] sum_q, sum_d;
  logic [3:0] dly_q, dly_d;

  // Loader write register: owns the memory port in every state except RUN.
  logic       wr_we_q, wr_we_d;
  logic [7:0] wr_adr_q, wr_adr_d;
  logic [7:0] wr_wd_q, wr_wd_d;

  logic       accept;
  logic       in_run;

  // Status outputs are decoded from the registered state only.
  assign s_ready   = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign busy      = s_ready;
  assign in_run    = (state_q == ST_RUN);
  assign done      = in_run;
  assign err       = (state_q == ST_ERR);
  assign cpu_reset = !in_run;
  assign accept    = s_valid && s_ready;

  // The memory port follows the core only while it runs; otherwise the loader owns it.
  assign mem_we  = in_run ? cpu_memwrite  : wr_we_q;
  assign mem_adr = in_run ? cpu_adr       : wr_adr_q;
  assign mem_wd  = in_run ? cpu_writedata : wr_wd_q;

  // Next-state and datapath update for the load sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d     = state_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    dly_d       = dly_q;
    wr_we_d     = 1'b0;       // a loader write lasts exactly one cycle
    wr_adr_d    = wr_adr_q;
    wr_wd_d     = wr_wd_q;

    unique case (state_q)
      ST_LEN: begin
        if (accept) begin
          remaining_d = (s_data == 8'h00) ? 9'd256 : {1'b0, s_data};
          idx_d       = 8'h00;
          sum_d       = 8'h00;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          wr_we_d     = 1'b1;
          wr_adr_d    = BASE_ADDR + idx_q;   // wraps naturally mod 256
          wr_wd_d     = s_data;
          sum_d       = sum_q + s_data;
          idx_d       = idx_q + 8'd1;
          remaining_d = remaining_q - 9'd1;
          if (remaining_q == 9'd1) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (s_data == sum_q) begin
            dly_d   = DLY_INIT;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_HOLD: begin
        if (dly_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      ST_RUN, ST_ERR: begin
        if (reload) begin
          state_d = ST_LEN;
        end
      end
      default: begin
        state_d = ST_LEN;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset drops any pending write.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (!reset) begin
      state_q     <= ST_LEN;
      remaining_q <= 9'd0;
      idx_q       <= 8'h00;
      sum_q       <= 8'h00;
      dly_q       <= 4'd0;
      wr_we_q     <= 1'b0;
      wr_adr_q    <= BASE_ADDR;
      wr_wd_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      dly_q       <= dly_d;
      wr_we_q     <= wr_we_d;
      wr_adr_q    <= wr_adr_d;
      wr_wd_q     <= wr_wd_d;
    end
  end

endmodule
